// File: rtl/ram_delay_line_ce_if.sv
// Streaming port bundle for ram_delay_line_ce: clock enable, input sample, delayed output.
interface ram_delay_line_ce_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  ce;
   logic [DATA_WIDTH-1:0] data_in;
   logic [DATA_WIDTH-1:0] data_out;

   modport master (output ce, output data_in, input data_out);
   modport slave  (input ce, input data_in, output data_out);
endinterface

// File: rtl/ram_delay_line_ce.sv
// Clock-enabled delay line on a circular-buffer RAM; latency is DELAY enabled edges.
// Optional macro RAM_DELAY_LINE_FILL_MASK_EN zeroes data_out until the buffer has filled.
module ram_delay_line_ce #(
   parameter int DATA_WIDTH = 8,
   parameter int DELAY      = 16
) (
   input  logic               clk,
   input  logic               rst,
   ram_delay_line_ce_if.slave bus
);
   localparam int ADDR_WIDTH = (DELAY > 1) ? $clog2(DELAY) : 1;

   logic [DATA_WIDTH-1:0] rd_data;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic                  full;

   generate
      if (DELAY < 1) begin : g_illegal
         $error("ram_delay_line_ce: DELAY must be >= 1");
         assign rd_data = '0;
      end else if (DELAY == 1) begin : g_reg
         logic [DATA_WIDTH-1:0] mem_q;
         always_ff @(posedge clk) begin
            if (!rst && bus.ce) mem_q <= bus.data_in;
         end
         assign rd_data = mem_q;
      end else begin : g_ram
         logic [DATA_WIDTH-1:0] mem_q [DELAY];
         logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

         // Read-before-write: rd_data is the old word at ptr_q, captured in dout_q this edge.
         assign rd_data = mem_q[ptr_q];

         always_ff @(posedge clk) begin
            if (!rst && bus.ce) mem_q[ptr_q] <= bus.data_in;
         end

         always_comb begin
            ptr_d = ptr_q;
            if (bus.ce) begin
               if (ptr_q == ADDR_WIDTH'(DELAY - 1)) ptr_d = '0;
               else                                 ptr_d = ptr_q + 1'b1;
            end
         end

         always_ff @(posedge clk) begin
            if (rst) ptr_q <= '0;
            else     ptr_q <= ptr_d;
         end
      end
   endgenerate

`ifdef RAM_DELAY_LINE_FILL_MASK_EN
   localparam int FILL_W = (DELAY > 0) ? $clog2(DELAY + 1) : 1;
   logic [FILL_W-1:0] fill_q, fill_d;

   assign full = (fill_q == FILL_W'(DELAY));

   always_comb begin
      fill_d = fill_q;
      if (bus.ce && !full) fill_d = fill_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) fill_q <= '0;
      else     fill_q <= fill_d;
   end
`else
   assign full = 1'b1;
`endif

   always_comb begin
      dout_d = dout_q;
      if (bus.ce) dout_d = full ? rd_data : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) dout_q <= '0;
      else     dout_q <= dout_d;
   end

   assign bus.data_out = dout_q;
endmodule

// File: tb/tb_ram_delay_line_ce.sv
// Directed bench for ram_delay_line_ce: line-buffer, hold, wrap, reset and minimum-depth cases.
module tb_ram_delay_line_ce;
   localparam int DW = 16;

   typedef struct {
      logic          rst;
      logic          ce;
      logic [DW-1:0] din;
      logic [DW-1:0] exp;
      logic          mask_only;
   } vec_t;

   logic clk;
   logic rst_a, rst4, rst1;
   int   n_chk, n_err;

   ram_delay_line_ce_if #(.DATA_WIDTH(DW)) i109 ();
   ram_delay_line_ce_if #(.DATA_WIDTH(DW)) i99 ();
   ram_delay_line_ce_if #(.DATA_WIDTH(DW)) i5 ();
   ram_delay_line_ce_if #(.DATA_WIDTH(DW)) i4 ();
   ram_delay_line_ce_if #(.DATA_WIDTH(DW)) i1 ();

   ram_delay_line_ce #(.DATA_WIDTH(DW), .DELAY(109)) u109 (.clk(clk), .rst(rst_a), .bus(i109));
   ram_delay_line_ce #(.DATA_WIDTH(DW), .DELAY(99))  u99  (.clk(clk), .rst(rst_a), .bus(i99));
   ram_delay_line_ce #(.DATA_WIDTH(DW), .DELAY(5))   u5   (.clk(clk), .rst(rst_a), .bus(i5));
   ram_delay_line_ce #(.DATA_WIDTH(DW), .DELAY(4))   u4   (.clk(clk), .rst(rst4),  .bus(i4));
   ram_delay_line_ce #(.DATA_WIDTH(DW), .DELAY(1))   u1   (.clk(clk), .rst(rst1),  .bus(i1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Before the buffer fills, output is defined only when the fill mask is compiled in.
   task automatic check_fill(input string nm, input logic [DW-1:0] act);
`ifdef RAM_DELAY_LINE_FILL_MASK_EN
      check(nm, act, '0);
`else
      if (act === 16'hxxxx) n_chk = n_chk + 0;
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   vec_t t4 [18];
   vec_t t1 [11];

   initial begin
      logic [DW-1:0] q109 [$];
      logic [DW-1:0] q99  [$];
      logic [DW-1:0] q5   [$];
      logic [DW-1:0] d;
      logic          de;
      int            n;

      t4 = '{
         '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0},
         '{1'b0, 1'b1, 16'h0010, 16'h0000, 1'b1},
         '{1'b0, 1'b1, 16'h0011, 16'h0000, 1'b1},
         '{1'b0, 1'b1, 16'h0012, 16'h0000, 1'b1},
         '{1'b0, 1'b1, 16'h0013, 16'h0000, 1'b1},
         '{1'b0, 1'b1, 16'h0014, 16'h0010, 1'b0},
         '{1'b0, 1'b1, 16'h0015, 16'h0011, 1'b0},
         '{1'b0, 1'b0, 16'h00EE, 16'h0011, 1'b0},
         '{1'b0, 1'b0, 16'h00EF, 16'h0011, 1'b0},
         '{1'b0, 1'b1, 16'h0016, 16'h0012, 1'b0},
         '{1'b1, 1'b1, 16'h0099, 16'h0000, 1'b0},
         '{1'b0, 1'b1, 16'h0010, 16'h0000, 1'b1},
         '{1'b0, 1'b1, 16'h0011, 16'h0000, 1'b1},
         '{1'b0, 1'b1, 16'h0012, 16'h0000, 1'b1},
         '{1'b0, 1'b1, 16'h0013, 16'h0000, 1'b1},
         '{1'b0, 1'b1, 16'h0014, 16'h0010, 1'b0},
         '{1'b0, 1'b1, 16'h0015, 16'h0011, 1'b0},
         '{1'b0, 1'b1, 16'h0016, 16'h0012, 1'b0}
      };
      t1 = '{
         '{1'b1, 1'b0, 16'h00A0, 16'h0000, 1'b0},
         '{1'b0, 1'b1, 16'h00A1, 16'h0000, 1'b1},
         '{1'b0, 1'b1, 16'h00A2, 16'h00A1, 1'b0},
         '{1'b0, 1'b0, 16'h00A3, 16'h00A1, 1'b0},
         '{1'b0, 1'b1, 16'h00A4, 16'h00A2, 1'b0},
         '{1'b0, 1'b1, 16'h00A5, 16'h00A4, 1'b0},
         '{1'b1, 1'b1, 16'h00A6, 16'h0000, 1'b0},
         '{1'b0, 1'b1, 16'h00A7, 16'h0000, 1'b1},
         '{1'b0, 1'b1, 16'h00A8, 16'h00A7, 1'b0},
         '{1'b0, 1'b0, 16'h00A9, 16'h00A7, 1'b0},
         '{1'b0, 1'b1, 16'h00AA, 16'h00A8, 1'b0}
      };

      n_chk = 0;
      n_err = 0;
      rst_a = 1'b1; rst4 = 1'b1; rst1 = 1'b1;
      i109.ce = 1'b0; i99.ce = 1'b0; i5.ce = 1'b0; i4.ce = 1'b0; i1.ce = 1'b0;
      i109.data_in = '0; i99.data_in = '0; i5.data_in = '0; i4.data_in = '0; i1.data_in = '0;
      repeat (2) tick();
      check("reset_d109", i109.data_out, '0);
      check("reset_d99",  i99.data_out,  '0);
      check("reset_d5",   i5.data_out,   '0);
      check("reset_d4",   i4.data_out,   '0);
      check("reset_d1",   i1.data_out,   '0);
      rst_a = 1'b0;

      // Lines of 100 active + 10 porch; d99 gated by de, d109 free-running on the same stream.
      for (int row = 1; row <= 3; row++) begin
         for (int col = 0; col < 110; col++) begin
            de = (col < 100);
            d  = de ? 16'(row * 256 + col + 1) : 16'(16'hF000 + col);
            i109.ce = 1'b1; i109.data_in = d;
            i99.ce  = de;   i99.data_in  = d;
            q109.push_back(d);
            if (de) q99.push_back(d);
            tick();
            n = q109.size();
            if (n > 109) check("pass109", i109.data_out, q109[n-110]);
            else         check_fill("fill109", i109.data_out);
            if (de) begin
               n = q99.size();
               if (n > 99) check("gated99", i99.data_out, q99[n-100]);
               else        check_fill("fill99", i99.data_out);
            end
            if (row == 2 && col < 99) begin
               check("row2_col", i99.data_out, 16'(16'h0102 + col));
               check("gated_vs_ff", i99.data_out, i109.data_out);
            end
         end
      end
      i109.ce = 1'b0;
      i99.ce  = 1'b0;

      // Wrap and hold on DELAY=5: ramp, freeze 10 edges with moving data, resume.
      for (int i = 0; i < 46; i++) begin
         i5.ce      = !(i >= 24 && i < 34);
         i5.data_in = 16'(16'h0050 + i);
         if (i5.ce) q5.push_back(i5.data_in);
         tick();
         n = q5.size();
         if (i >= 24 && i < 34)  check("hold5", i5.data_out, q5[n-6]);
         else if (n > 5)         check("wrap5", i5.data_out, q5[n-6]);
         else                    check_fill("fill5", i5.data_out);
      end
      i5.ce = 1'b0;

      // Reset mid-stream, rst+ce priority, DELAY=4.
      for (int i = 0; i < 18; i++) begin
         rst4 = t4[i].rst; i4.ce = t4[i].ce; i4.data_in = t4[i].din;
         tick();
         if (t4[i].mask_only) check_fill("rst4_fill", i4.data_out);
         else                 check("rst4", i4.data_out, t4[i].exp);
      end
      i4.ce = 1'b0;

      // Minimum depth, DELAY=1.
      for (int i = 0; i < 11; i++) begin
         rst1 = t1[i].rst; i1.ce = t1[i].ce; i1.data_in = t1[i].din;
         tick();
         if (t1[i].mask_only) check_fill("d1_fill", i1.data_out);
         else                 check("d1", i1.data_out, t1[i].exp);
      end
      i1.ce = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
